// File: rtl/uart_line_packer.sv
// Packs bytes popped from the async byte FIFO into words and a LINE_WORDS-word line,
// then offers the line with valid/ready. Idle partial lines are flushed after TIMEOUT cycles.
module uart_line_packer #(
    parameter int WORD_BYTES = 4,
    parameter int LINE_WORDS = 8,
    parameter int MSB_FIRST  = 0,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 11,
    localparam int LINE_BYTES = WORD_BYTES * LINE_WORDS,
    localparam int LINE_W     = 8 * LINE_BYTES,
    localparam int BCNT_W     = $clog2(LINE_BYTES + 1)
) (
    input  logic                    axi_clk,
    input  logic                    i_rstn,
    input  logic                    fifo_empty,
    output logic                    read_en,
    input  logic [7:0]              i_data,
    output logic [LINE_W-1:0]       o_line,
    output logic [LINE_BYTES-1:0]   o_line_mask,
    output logic                    o_line_valid,
    input  logic                    i_line_ready,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_valid,
    output logic [BCNT_W-1:0]       o_byte_cnt,
    output logic                    o_line_done
);
    typedef enum logic [1:0] {IDLE, REQ, CAP, OUT} state_e;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                     state_q;
    logic [LINE_BYTES-1:0][7:0] line_q, line_d;
    logic [LINE_BYTES-1:0]      mask_q, mask_d;
    logic [WORD_BYTES-1:0][7:0] wsr_q, wsr_d, word_q;
    logic [BCNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]           tmo_q;
    logic                       read_en_q, line_vld_q, word_vld_q, done_q;
    logic                       word_end, line_end;
    int                         slot;

    // The mask bit tracks the physical byte position, so it mirrors with MSB_FIRST.
    always_comb begin
        slot   = (MSB_FIRST != 0) ? LINE_BYTES - 1 - int'(cnt_q) : int'(cnt_q);
        line_d = line_q;
        mask_d = mask_q;
        for (int b = 0; b < LINE_BYTES; b++) begin
            if (b == slot) begin
                line_d[b] = i_data;
                mask_d[b] = 1'b1;
            end
        end
        wsr_d = wsr_q;
        if (MSB_FIRST != 0) begin
            wsr_d[0] = i_data;
            for (int j = 1; j < WORD_BYTES; j++) wsr_d[j] = wsr_q[j-1];
        end else begin
            for (int j = 0; j < WORD_BYTES - 1; j++) wsr_d[j] = wsr_q[j+1];
            wsr_d[WORD_BYTES-1] = i_data;
        end
        word_end = ((int'(cnt_q) + 1) % WORD_BYTES) == 0;
        line_end = (int'(cnt_q) + 1) == LINE_BYTES;
    end

    always_ff @(posedge axi_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            line_q     <= '0;
            mask_q     <= '0;
            wsr_q      <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            read_en_q  <= 1'b0;
            line_vld_q <= 1'b0;
            word_vld_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            read_en_q  <= 1'b0;
            word_vld_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A pending byte beats a flush that would fire in the same cycle.
                    if (!fifo_empty) begin
                        state_q   <= REQ;
                        read_en_q <= 1'b1;
                        tmo_q     <= '0;
                    end else if (TIMEOUT != 0 && cnt_q != '0) begin
                        if (tmo_q == TMO_LAST) begin
                            state_q    <= OUT;
                            line_vld_q <= 1'b1;
                            tmo_q      <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                REQ: state_q <= CAP;
                CAP: begin
                    line_q <= line_d;
                    mask_q <= mask_d;
                    wsr_q  <= wsr_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (word_end) begin
                        word_q     <= wsr_d;
                        word_vld_q <= 1'b1;
                    end
                    if (line_end) begin
                        state_q    <= OUT;
                        line_vld_q <= 1'b1;
                    end else if (!fifo_empty) begin
                        state_q   <= REQ;
                        read_en_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OUT: begin
                    if (i_line_ready) begin
                        state_q    <= IDLE;
                        line_vld_q <= 1'b0;
                        done_q     <= 1'b1;
                        line_q     <= '0;
                        mask_q     <= '0;
                        cnt_q      <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_en      = read_en_q;
    assign o_line       = line_q;
    assign o_line_mask  = mask_q;
    assign o_line_valid = line_vld_q;
    assign o_word       = word_q;
    assign o_word_valid = word_vld_q;
    assign o_byte_cnt   = cnt_q;
    assign o_line_done  = done_q;
endmodule

// File: tb/tb_uart_line_packer.sv
// Scoreboard bench: an LSB-first and an MSB-first packer share one byte FIFO model;
// stimulus queues expected lines/words, a negedge monitor pops and compares.
module tb_uart_line_packer;
    typedef struct packed {
        logic [255:0] line;
        logic [31:0]  mask;
    } line_t;

    logic         axi_clk = 1'b0;
    logic         i_rstn;
    logic         fifo_empty = 1'b1;
    logic [7:0]   fifo_data = 8'h00;
    logic         i_line_ready;
    logic         re_w   [2];
    logic [255:0] line_w [2];
    logic [31:0]  mask_w [2];
    logic         lv_w   [2];
    logic [31:0]  word_w [2];
    logic         wv_w   [2];
    logic [5:0]   bcnt_w [2];
    logic         done_w [2];

    logic [7:0] fifo_q[$];
    line_t      lq0[$], lq1[$];
    logic [31:0] wq0[$], wq1[$];

    int checks = 0, errors = 0;
    int cyc = 0, nreads = 0, ndone = 0, last_req_cyc = 0, rise_cyc = 0;
    logic [1:0] prev_hs = '0;
    logic lv_prev = 1'b0;

    always #5 axi_clk = ~axi_clk;
    always @(posedge axi_clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_line_packer #(
            .WORD_BYTES(4), .LINE_WORDS(8), .MSB_FIRST(g), .TIMEOUT(16), .CNT_W(11)
        ) dut (
            .axi_clk(axi_clk), .i_rstn(i_rstn), .fifo_empty(fifo_empty), .read_en(re_w[g]),
            .i_data(fifo_data), .o_line(line_w[g]), .o_line_mask(mask_w[g]),
            .o_line_valid(lv_w[g]), .i_line_ready(i_line_ready), .o_word(word_w[g]),
            .o_word_valid(wv_w[g]), .o_byte_cnt(bcnt_w[g]), .o_line_done(done_w[g])
        );
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Byte FIFO model: pops on the LSB-first packer's strobe; empty flag is registered.
    always @(posedge axi_clk) begin
        if (re_w[0]) begin
            if (fifo_q.size() == 0) chk("fifo_underflow", 1, 0);
            else fifo_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge axi_clk) begin
        if (!i_rstn) begin
            prev_hs = '0;
            lv_prev = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                line_t e;
                logic [31:0] w;
                if (done_w[d] || prev_hs[d]) chk("line_done", done_w[d], prev_hs[d]);
                prev_hs[d] = lv_w[d] && i_line_ready;
                if (prev_hs[d]) begin
                    if ((d == 0 ? lq0.size() : lq1.size()) == 0) chk("unexpected_line", 1, 0);
                    else begin
                        if (d == 0) e = lq0.pop_front(); else e = lq1.pop_front();
                        chk(d == 0 ? "line_lsb" : "line_msb", line_w[d], e.line);
                        chk(d == 0 ? "mask_lsb" : "mask_msb", mask_w[d], e.mask);
                    end
                end
                if (wv_w[d]) begin
                    if ((d == 0 ? wq0.size() : wq1.size()) == 0) chk("unexpected_word", 1, 0);
                    else begin
                        if (d == 0) w = wq0.pop_front(); else w = wq1.pop_front();
                        chk(d == 0 ? "word_lsb" : "word_msb", word_w[d], w);
                    end
                end
            end
            if (done_w[0]) ndone++;
            if (re_w[0]) begin
                nreads++;
                last_req_cyc = cyc;
            end
            if (lv_w[0] && !lv_prev) rise_cyc = cyc;
            lv_prev = lv_w[0];
        end
    end

    function automatic line_t mk_line(input logic [7:0] s, input int n, input bit msb);
        line_t r = '0;
        for (int i = 0; i < n; i++) begin
            if (msb) begin
                r.line[255-8*i -: 8] = s + 8'(i);
                r.mask[31-i] = 1'b1;
            end else begin
                r.line[8*i +: 8] = s + 8'(i);
                r.mask[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mk_word(input logic [7:0] s, input bit msb);
        return msb ? {s, s + 8'd1, s + 8'd2, s + 8'd3} : {s + 8'd3, s + 8'd2, s + 8'd1, s};
    endfunction

    task automatic expect_words(input logic [7:0] s, input int n);
        for (int w = 0; w < n / 4; w++) begin
            wq0.push_back(mk_word(s + 8'(4*w), 1'b0));
            wq1.push_back(mk_word(s + 8'(4*w), 1'b1));
        end
    endtask

    task automatic expect_line(input logic [7:0] s, input int n);
        lq0.push_back(mk_line(s, n, 1'b0));
        lq1.push_back(mk_line(s, n, 1'b1));
    endtask

    task automatic push_bytes(input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(s + 8'(i));
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (ndone < n && k < 2000) begin
            @(negedge axi_clk);
            k++;
        end
        chk("line_done_count", ndone, n);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!lv_w[0] && k < 500) begin
            @(negedge axi_clk);
            k++;
        end
        chk("line_valid_timeout", lv_w[0], 1);
    endtask

    task automatic chk_zero(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk(nm, line_w[d], 0);
            chk(nm, mask_w[d], 0);
            chk(nm, {word_w[d], bcnt_w[d], lv_w[d], wv_w[d], done_w[d], re_w[d]}, 0);
        end
    endtask

    initial begin
        int r, k, rd0, done0;
        logic [255:0] snap;
        i_rstn = 1'b0;
        i_line_ready = 1'b0;
        repeat (3) @(negedge axi_clk);
        chk_zero("reset_state");
        i_rstn = 1'b1;

        // Full line of 0x00..0x1F with ready held high.
        i_line_ready = 1'b1;
        lq0.push_back('{256'h1F1E1D1C1B1A19181716151413121110_0F0E0D0C0B0A09080706050403020100, 32'hFFFFFFFF});
        lq1.push_back('{256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F, 32'hFFFFFFFF});
        wq0.push_back(32'h03020100);
        wq1.push_back(32'h00010203);
        for (int w = 1; w < 8; w++) begin
            wq0.push_back(mk_word(8'(4*w), 1'b0));
            wq1.push_back(mk_word(8'(4*w), 1'b1));
        end
        push_bytes(8'h00, 32);
        wait_done(1);
        chk("reads_full_line", nreads, 32);

        // Partial line flushed by timeout.
        lq0.push_back('{256'hA4A3A2A1A0, 32'h0000001F});
        lq1.push_back('{{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 216'h0}, 32'hF8000000});
        wq0.push_back(32'hA3A2A1A0);
        wq1.push_back(32'hA0A1A2A3);
        push_bytes(8'hA0, 5);
        wait_done(2);
        chk("flush_latency", rise_cyc - last_req_cyc, 18);

        // Second byte lands on the last idle count before the flush: no flush, counter restarts.
        expect_line(8'h11, 2);
        fifo_q.push_back(8'h11);
        k = 0;
        while (!re_w[0] && k < 100) begin
            @(negedge axi_clk);
            k++;
        end
        r = cyc;
        while (cyc != r + 16) @(negedge axi_clk);
        fifo_q.push_back(8'h12);
        wait_done(3);
        chk("cancel_flush_latency", rise_cyc - last_req_cyc, 18);

        // Back-pressure: 40 bytes queued, ready held low for 50 cycles.
        i_line_ready = 1'b0;
        rd0 = nreads;
        expect_line(8'h40, 32);
        expect_line(8'h60, 8);
        expect_words(8'h40, 40);
        push_bytes(8'h40, 40);
        wait_valid();
        snap = line_w[0];
        r = nreads;
        repeat (50) @(negedge axi_clk);
        chk("bp_line_frozen", line_w[0], snap);
        chk("bp_valid_held", lv_w[0], 1);
        chk("bp_no_reads", nreads - r, 0);
        i_line_ready = 1'b1;
        wait_done(5);
        chk("bp_total_reads", nreads - rd0, 40);

        // Reset mid-line at 10 bytes.
        expect_words(8'h80, 10);
        push_bytes(8'h80, 10);
        k = 0;
        while (bcnt_w[0] != 6'd10 && k < 200) begin
            @(negedge axi_clk);
            k++;
        end
        chk("midline_cnt", bcnt_w[0], 10);
        #2 i_rstn = 1'b0;
        #1 chk_zero("reset_midline");
        @(negedge axi_clk);
        i_rstn = 1'b1;

        // Reset while a full line waits in OUT.
        i_line_ready = 1'b0;
        done0 = ndone;
        expect_words(8'h20, 32);
        push_bytes(8'h20, 32);
        wait_valid();
        #2 i_rstn = 1'b0;
        #1 chk_zero("reset_out");
        @(negedge axi_clk);
        i_rstn = 1'b1;
        repeat (3) @(negedge axi_clk);
        chk("no_done_after_reset", ndone, done0);

        // Next line starts at slot 0.
        i_line_ready = 1'b1;
        expect_line(8'hC0, 3);
        push_bytes(8'hC0, 3);
        wait_done(6);

        repeat (5) @(negedge axi_clk);
        chk("lines_left", lq0.size() + lq1.size(), 0);
        chk("words_left", wq0.size() + wq1.size(), 0);
        chk("fifo_left", fifo_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_line_packer.md
# uart_line_packer

Parametrised successor to the byte-to-word shifter and 8-word line register in the UART-to-DDR3 path. The block sits in the `axi_clk` domain on the read side of the asynchronous byte FIFO. It pops received UART bytes, packs them into WORD_BYTES-wide words and then into a LINE_WORDS-word line, and presents the line with a valid/ready handshake to the DDR3 write path. It adds a configurable byte order, a timeout flush of partial lines with a byte mask, and back-pressure, none of which the fixed 256-bit version has.

## Interface
Parameters:
- WORD_BYTES, 4, bytes per word (1..8)
- LINE_WORDS, 8, words per line (1..16); LINE_BYTES = WORD_BYTES*LINE_WORDS; LINE_W = 8*LINE_BYTES (256 at defaults)
- MSB_FIRST, 0, byte order: 0 = first byte in line[7:0]; 1 = first byte in line[LINE_W-1 -: 8]
- TIMEOUT, 1024, idle cycles before a partial line is flushed; 0 = never flush
- CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
- axi_clk  in  1  sole clock; all logic is on its rising edge
- i_rstn  in  1  asynchronous, active-low reset
- fifo_empty  in  1  byte FIFO empty flag
- read_en  out  1  FIFO pop strobe; data is valid on `i_data` the cycle after
- i_data  in  8  FIFO read data
- o_line  out  LINE_W  assembled line, stable while `o_line_valid` is high
- o_line_mask  out  LINE_BYTES  1 per valid byte position of `o_line`
- o_line_valid  out  1  line available
- i_line_ready  in  1  consumer accepts the line
- o_word  out  8*WORD_BYTES  most recently completed word, in the same byte order as the line
- o_word_valid  out  1  one-cycle pulse when `o_word` updates
- o_byte_cnt  out  $clog2(LINE_BYTES+1)  bytes in the current line
- o_line_done  out  1  one-cycle pulse on line handshake (the trigger flag)

## Operation
- Reset values: all outputs 0; state IDLE; byte and timeout counters 0.
- States are IDLE, REQ, CAP and OUT.
- **IDLE:**
  - If `!fifo_empty`, go to REQ.
  - Else if `o_byte_cnt>0` and TIMEOUT≠0, increment the timeout counter.
  - When the counter reaches TIMEOUT, go to OUT (partial flush).
  - The counter clears on any transition out of IDLE.
- **REQ:** `read_en`=1 for exactly this cycle, then go to CAP.
- **CAP:**
  - Write `i_data` into byte slot `o_byte_cnt`: bits [8k+7:8k] when MSB_FIRST=0, or bits [LINE_W-1-8k -: 8] when MSB_FIRST=1.
  - Set mask bit k and increment `o_byte_cnt`.
  - If (k+1) mod WORD_BYTES = 0, update `o_word` from the just-completed word and pulse `o_word_valid`.
  - If k+1 = LINE_BYTES, go to OUT.
  - Else if `!fifo_empty`, go to REQ; otherwise go to IDLE.
- **OUT:**
  - `o_line_valid`=1; `o_line` and `o_line_mask` are frozen and no FIFO reads are issued.
  - On `o_line_valid && i_line_ready`, pulse `o_line_done`, clear line, mask and `o_byte_cnt` next cycle, and return to IDLE.
- Unfilled byte positions of a partial line read as 0.
- `o_word` is not updated for a trailing partial word.

## Timing
- Read latency: one byte per 2 cycles sustained (REQ and CAP).
- Line latency:
  - A full line is valid the cycle after the CAP of the last byte.
  - A partial line is valid TIMEOUT+1 cycles after the last CAP with the FIFO empty.
- Handshake:
  - `o_line_valid` stays high until accepted and never drops without `i_line_ready`.
  - `i_line_ready` may be high before valid; acceptance then takes 1 cycle in OUT.
- `fifo_empty` is sampled only in IDLE and CAP. `read_en` is never asserted when `fifo_empty` was 1 in the deciding cycle.
- A byte arriving while the timeout counter is running cancels the flush: go to REQ and clear the counter.
- If the count hits TIMEOUT in the same cycle `fifo_empty` falls, the FIFO read wins.
- Back-pressure: while in OUT the FIFO fills. The upstream almost-full flag throttles the UART FSM, and no bytes are lost in this block.
- Reset asserted mid-line or in OUT: line, mask and counters clear immediately. The partial line is discarded and `o_line_done` is not pulsed.

## Test plan
- Defaults, 32 bytes 0x00..0x1F pushed → exactly 32 `read_en` pulses; `o_line`=0x1F1E…0100; mask all ones; 8 `o_word_valid` pulses, first `o_word`=0x03020100; `i_line_ready`=1 gives a one-cycle `o_line_done`.
- MSB_FIRST=1, same bytes → `o_line`=0x00010203…1E1F; first `o_word`=0x00010203.
- TIMEOUT=16, 5 bytes 0xA0..0xA4 then FIFO empty → `o_line_valid` 17 cycles after the last CAP; `o_line[39:0]`=0xA4A3A2A1A0, rest 0; mask=0x0000001F; only one `o_word_valid` (0xA3A2A1A0).
- `i_line_ready` held low 50 cycles with 40 bytes queued → `o_line` and `read_en` frozen; after ready, bytes 32..39 fill the next line in order with none dropped.
- TIMEOUT=16, byte arrives at counter=15 → no flush; `o_byte_cnt` increments; counter restarts from 0.
- `i_rstn` pulsed low during OUT and mid-line (cnt=10) → all outputs 0 asynchronously; next line starts at slot 0.
